// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared cell geometry constants, FSM state type and counter helper
package atm_pkg;

    localparam int CELL_BYTES = 53;
    localparam int HDR_BYTES  = 4;
    localparam int HEC_IDX    = 4;

    localparam logic [5:0] LAST_IDX = 6'(CELL_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK,
        SEND
    } rx_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/atm_hec_crc8.sv
// rtl/atm_hec_crc8.sv - one octet step of the HEC CRC-8 (x^8+x^2+x+1), MSB first
module atm_hec_crc8 (
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/atm_utopia_rx_cell.sv
// rtl/atm_utopia_rx_cell.sv - Utopia Rx cell receiver: buffers one cell, checks HEC, streams it to the router
module atm_utopia_rx_cell
    import atm_pkg::*;
#(
    parameter logic [7:0] HEC_COSET = 8'h55,
    parameter bit         DROP_BAD  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        Rx_clk,
    input  logic [7:0]  Rx_data,
    input  logic        Rx_soc,
    output logic        Rx_en,
    input  logic        Rx_clav,
    output logic [7:0]  cell_data,
    output logic        cell_valid,
    output logic        cell_sop,
    output logic        cell_eop,
    output logic        cell_err,
    input  logic        cell_ready,
    output logic [15:0] hec_err_cnt,
    output logic [15:0] cell_cnt
);

    logic [7:0] cell_buf [CELL_BYTES];
    rx_state_e  state;
    logic [5:0] wr_idx;
    logic [5:0] rd_idx;
    logic       started;
    logic       rst_ok;
    logic [7:0] crc;
    logic [7:0] crc_next;
    logic       capture;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic       hec_bad;

    assign Rx_clk  = clk;
    assign capture = (state == RECV) && !Rx_en;
    assign wr_en   = capture && (Rx_soc || started);
    assign wr_addr = Rx_soc ? 6'd0 : wr_idx;
    assign hec_bad = ((crc ^ HEC_COSET) != cell_buf[HEC_IDX]);

    // A start-of-cell octet always restarts the CRC from zero.
    atm_hec_crc8 u_hec (
        .crc_in  (Rx_soc ? 8'h00 : crc),
        .data    (Rx_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            cell_buf[wr_addr] <= Rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            Rx_en       <= 1'b1;
            wr_idx      <= 6'd0;
            rd_idx      <= 6'd0;
            started     <= 1'b0;
            rst_ok      <= 1'b0;
            crc         <= 8'h00;
            cell_valid  <= 1'b0;
            cell_data   <= 8'h00;
            cell_sop    <= 1'b0;
            cell_eop    <= 1'b0;
            cell_err    <= 1'b0;
            hec_err_cnt <= 16'd0;
            cell_cnt    <= 16'd0;
        end else begin
            // Holds off the first PHY read until the second edge after release.
            rst_ok <= 1'b1;
            case (state)
                IDLE: begin
                    if (Rx_clav && rst_ok) begin
                        state   <= RECV;
                        Rx_en   <= 1'b0;
                        started <= 1'b0;
                        wr_idx  <= 6'd0;
                    end
                end
                RECV: begin
                    if (capture) begin
                        if (Rx_soc) begin
                            started <= 1'b1;
                            wr_idx  <= 6'd1;
                            crc     <= crc_next;
                        end else if (started) begin
                            if (wr_idx < 6'(HDR_BYTES)) begin
                                crc <= crc_next;
                            end
                            if (wr_idx == LAST_IDX) begin
                                Rx_en <= 1'b1;
                                state <= CHECK;
                            end else begin
                                wr_idx <= wr_idx + 6'd1;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (hec_bad) begin
                        hec_err_cnt <= sat_inc(hec_err_cnt);
                    end
                    if (hec_bad && DROP_BAD) begin
                        state <= IDLE;
                    end else begin
                        state    <= SEND;
                        cell_err <= hec_bad;
                        rd_idx   <= 6'd0;
                    end
                end
                SEND: begin
                    if (!cell_valid) begin
                        cell_valid <= 1'b1;
                        cell_data  <= cell_buf[0];
                        cell_sop   <= 1'b1;
                        cell_eop   <= 1'b0;
                    end else if (cell_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            cell_valid <= 1'b0;
                            cell_eop   <= 1'b0;
                            cell_err   <= 1'b0;
                            cell_cnt   <= sat_inc(cell_cnt);
                            state      <= IDLE;
                        end else begin
                            rd_idx    <= rd_idx + 6'd1;
                            cell_data <= cell_buf[rd_idx + 6'd1];
                            cell_sop  <= 1'b0;
                            cell_eop  <= ((rd_idx + 6'd1) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_utopia_rx_cell.sv
// tb/tb_atm_utopia_rx_cell.sv - table-driven scoreboard bench for atm_utopia_rx_cell
module tb_atm_utopia_rx_cell;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_soc;
    logic        clav_a, clav_b;
    logic        cell_ready;

    logic        a_rx_clk, a_en, a_valid, a_sop, a_eop, a_err;
    logic [7:0]  a_data;
    logic [15:0] a_hec, a_cnt;
    logic        b_rx_clk, b_en, b_valid, b_sop, b_eop, b_err;
    logic [7:0]  b_data;
    logic [15:0] b_hec, b_cnt;

    atm_utopia_rx_cell #(.HEC_COSET(8'h55), .DROP_BAD(1'b1)) dut_a (
        .clk(clk), .rst(rst), .Rx_clk(a_rx_clk), .Rx_data(rx_data), .Rx_soc(rx_soc),
        .Rx_en(a_en), .Rx_clav(clav_a), .cell_data(a_data), .cell_valid(a_valid),
        .cell_sop(a_sop), .cell_eop(a_eop), .cell_err(a_err), .cell_ready(cell_ready),
        .hec_err_cnt(a_hec), .cell_cnt(a_cnt)
    );

    atm_utopia_rx_cell #(.HEC_COSET(8'h55), .DROP_BAD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .Rx_clk(b_rx_clk), .Rx_data(rx_data), .Rx_soc(rx_soc),
        .Rx_en(b_en), .Rx_clav(clav_b), .cell_data(b_data), .cell_valid(b_valid),
        .cell_sop(b_sop), .cell_eop(b_eop), .cell_err(b_err), .cell_ready(cell_ready),
        .hec_err_cnt(b_hec), .cell_cnt(b_cnt)
    );

    typedef struct { logic [7:0] d; logic s; } octet_t;
    typedef struct { logic [7:0] d; logic sop; logic eop; logic err; } exp_t;
    typedef struct {
        bit          inst;
        logic [31:0] hdr;
        logic [7:0]  hec;
        logic [7:0]  pay;
        logic [7:0]  inc;
        int          lead;
        int          abort_at;
        bit          tog;
        bit          exp_err;
    } vec_t;

    octet_t phy_q[$];
    exp_t   sb_q[$];
    bit     sel = 1'b0;
    bit     tog = 1'b0;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     since = 0;
    int     last_high = 0;
    bit     prev_en = 1'b1;
    bit     prev_valid = 1'b0;

    logic        m_en, m_valid, m_sop, m_eop, m_err;
    logic [7:0]  m_data;
    logic [15:0] m_hec, m_cnt;
    assign m_en    = sel ? b_en    : a_en;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_sop   = sel ? b_sop   : a_sop;
    assign m_eop   = sel ? b_eop   : a_eop;
    assign m_err   = sel ? b_err   : a_err;
    assign m_data  = sel ? b_data  : a_data;
    assign m_hec   = sel ? b_hec   : a_hec;
    assign m_cnt   = sel ? b_cnt   : a_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] octet_val(input logic [31:0] hdr, input logic [7:0] hec,
                                             input logic [7:0] pay, input logic [7:0] inc, input int i);
        if (i < 4) return hdr[31 - 8*i -: 8];
        if (i == 4) return hec;
        return 8'(int'(pay) + int'(inc) * (i - 5));
    endfunction

    task automatic push_cell(input logic [31:0] hdr, input logic [7:0] hec, input logic [7:0] pay,
                             input logic [7:0] inc, input int n, input bit expect_out, input bit err);
        for (int i = 0; i < n; i++) begin
            octet_t o;
            o.d = octet_val(hdr, hec, pay, inc, i);
            o.s = (i == 0);
            phy_q.push_back(o);
        end
        if (expect_out) begin
            for (int i = 0; i < 53; i++) begin
                exp_t e;
                e.d = octet_val(hdr, hec, pay, inc, i);
                e.sop = (i == 0);
                e.eop = (i == 52);
                e.err = err;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (phy_q.size() == 0 && sb_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("timeout_cell_done", 32'd0, 32'd1);
        repeat (8) @(negedge clk);
    endtask

    // PHY model: presents the next octet whenever the selected port holds Rx_en low.
    initial begin
        octet_t o;
        forever begin
            @(negedge clk);
            clav_a = !sel && (phy_q.size() > 0);
            clav_b =  sel && (phy_q.size() > 0);
            if (rst && !m_en && phy_q.size() > 0) begin
                o = phy_q.pop_front();
                rx_data = o.d;
                rx_soc  = o.s;
            end else begin
                rx_data = 8'h00;
                rx_soc  = 1'b0;
            end
        end
    end

    // Router model and scoreboard consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cell_ready = tog ? ~cell_ready : 1'b1;
            if (m_valid) begin
                chk("rx_en_high_while_sending", {31'd0, m_en}, 32'd1);
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", {31'd0, m_valid}, 32'd0);
                end else begin
                    e = sb_q[0];
                    chk("octet_sop_eop_err_data", {21'd0, m_sop, m_eop, m_err, m_data},
                        {21'd0, e.sop, e.eop, e.err, e.d});
                    if (cell_ready) void'(sb_q.pop_front());
                end
            end
            if (!prev_en && m_en) since = 0;
            else since++;
            if (prev_en && !m_en) last_high = since;
            if (!prev_valid && m_valid) chk("first_valid_latency", since, 2);
            prev_en    = m_en;
            prev_valid = m_valid;
        end
    end

    vec_t vecs[7];
    int   exp_cnt_a = 0, exp_hec_a = 0, exp_cnt_b = 0, exp_hec_b = 0;

    initial begin
        bit fwd;
        bit reached;
        rst = 1'b0; rx_data = 8'h00; rx_soc = 1'b0; clav_a = 1'b0; clav_b = 1'b0; cell_ready = 1'b1;
        vecs[0] = '{1'b0, 32'h0000_0001, 8'h52, 8'h6A, 8'h00, 0, 0,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0001, 8'h53, 8'h6A, 8'h00, 0, 0,  1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'h0000_0002, 8'h5B, 8'h10, 8'h01, 3, 20, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0001, 8'h52, 8'hC0, 8'h07, 0, 0,  1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0000, 8'h55, 8'h6A, 8'h00, 0, 0,  1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0000, 8'h00, 8'h20, 8'h01, 0, 0,  1'b0, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0002, 8'h5B, 8'h33, 8'h05, 0, 0,  1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_rx_en",  {31'd0, a_en},    32'd1);
        chk("reset_valid",  {31'd0, a_valid}, 32'd0);
        chk("reset_flags",  {29'd0, a_sop, a_eop, a_err}, 32'd0);
        chk("reset_data",   {24'd0, a_data},  32'd0);
        chk("reset_counts", {a_hec, a_cnt},   32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            sel = vecs[v].inst;
            tog = vecs[v].tog;
            for (int j = 0; j < vecs[v].lead; j++) phy_q.push_back('{8'hFF, 1'b0});
            if (vecs[v].abort_at > 0)
                push_cell(vecs[v].hdr, vecs[v].hec, vecs[v].pay ^ 8'hFF, vecs[v].inc,
                          vecs[v].abort_at, 1'b0, 1'b0);
            fwd = !vecs[v].exp_err || vecs[v].inst;
            push_cell(vecs[v].hdr, vecs[v].hec, vecs[v].pay, vecs[v].inc, 53, fwd, vecs[v].exp_err);
            if (sel) begin exp_cnt_b += int'(fwd); exp_hec_b += int'(vecs[v].exp_err); end
            else     begin exp_cnt_a += int'(fwd); exp_hec_a += int'(vecs[v].exp_err); end
            wait_done(3000);
            tog = 1'b0;
            chk($sformatf("vec%0d_cell_cnt", v),    {16'd0, m_cnt}, sel ? exp_cnt_b : exp_cnt_a);
            chk($sformatf("vec%0d_hec_err_cnt", v), {16'd0, m_hec}, sel ? exp_hec_b : exp_hec_a);
        end

        // Dropped cell followed directly by a good one: Rx_en must fall again quickly.
        sel = 1'b0;
        push_cell(32'h0000_0001, 8'h53, 8'h6A, 8'h00, 53, 1'b0, 1'b1);
        push_cell(32'h0000_0001, 8'h52, 8'h44, 8'h02, 53, 1'b1, 1'b0);
        exp_cnt_a++; exp_hec_a++;
        wait_done(3000);
        chk("drop_rx_en_relow_within_2", {31'd0, last_high <= 2}, 32'd1);
        chk("drop_seq_cell_cnt",    {16'd0, a_cnt}, exp_cnt_a);
        chk("drop_seq_hec_err_cnt", {16'd0, a_hec}, exp_hec_a);

        // Reset around octet 30, then one clean cell.
        push_cell(32'h0000_0001, 8'h52, 8'h11, 8'h01, 53, 1'b1, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(negedge clk);
            if (phy_q.size() <= 23) reached = 1'b1;
        end
        if (!reached) chk("timeout_octet30", 32'd0, 32'd1);
        #1;
        rst = 1'b0;
        phy_q.delete();
        sb_q.delete();
        #1;
        chk("midreset_rx_en",  {31'd0, a_en},    32'd1);
        chk("midreset_valid",  {31'd0, a_valid}, 32'd0);
        chk("midreset_flags",  {29'd0, a_sop, a_eop, a_err}, 32'd0);
        chk("midreset_data",   {24'd0, a_data},  32'd0);
        chk("midreset_counts", {a_hec, a_cnt},   32'd0);
        repeat (3) @(negedge clk);
        chk("midreset_hold_valid", {31'd0, a_valid}, 32'd0);
        rst = 1'b1;
        push_cell(32'h0000_0002, 8'h5B, 8'h77, 8'h03, 53, 1'b1, 1'b0);
        wait_done(3000);
        chk("post_reset_cell_cnt",    {16'd0, a_cnt}, 32'd1);
        chk("post_reset_hec_err_cnt", {16'd0, a_hec}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
